// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding ID: owns the fetch PC, issues in-order word
// requests to imem, tags them with an epoch and buffers kept responses for ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC,
  input  logic        Request_Alt_PC,
  input  logic        WANT_FREEZE,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr1_out,
  output logic [31:0] instr_pc_out,
  output logic [31:0] instr_pc_plus4_out,
  output logic        instr_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic          r_epoch;

  logic [31:0]   r_tag_pc [DEPTH];
  logic          r_tag_ep [DEPTH];
  logic [AW-1:0] r_tag_wr;
  logic [AW-1:0] r_tag_rd;
  logic [CW-1:0] r_outstanding;

  logic [31:0]   r_buf_pc  [DEPTH];
  logic [31:0]   r_buf_ins [DEPTH];
  logic [AW-1:0] r_buf_wr;
  logic [AW-1:0] r_buf_rd;
  logic [CW-1:0] r_buf_count;

  logic [31:0]   r_instr;
  logic [31:0]   r_pc;
  logic [31:0]   r_pc4;
  logic          r_valid;

  logic          w_credit;
  logic          w_req;
  logic          w_tag_push;
  logic          w_resp;
  logic          w_buf_push;
  logic          w_buf_pop;

  // Credits cover both in-flight requests and buffered words, so the buffer
  // can never overflow no matter how long ID holds halt.
  assign w_credit   = ({1'b0, r_outstanding} + {1'b0, r_buf_count}) < (CW+1)'(DEPTH);
  assign w_req      = RESET & ~Request_Alt_PC & ~WANT_FREEZE & ~halt & w_credit;
  assign w_tag_push = w_req & imem_gnt;
  assign w_resp     = RESET & imem_rvalid & (r_outstanding != '0);
  assign w_buf_push = w_resp & (r_tag_ep[r_tag_rd] == r_epoch) & ~Request_Alt_PC;
  assign w_buf_pop  = ~halt & ~Request_Alt_PC & (r_buf_count != '0);

  assign imem_req           = w_req;
  assign imem_addr          = r_fetch_pc;
  assign instr1_out         = r_instr;
  assign instr_pc_out       = r_pc;
  assign instr_pc_plus4_out = r_pc4;
  assign instr_valid        = r_valid;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_fetch_pc    <= RESET_PC;
      r_epoch       <= 1'b0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_outstanding <= '0;
      r_buf_wr      <= '0;
      r_buf_rd      <= '0;
      r_buf_count   <= '0;
      r_instr       <= '0;
      r_pc          <= '0;
      r_pc4         <= '0;
      r_valid       <= 1'b0;
    end else begin
      if (Request_Alt_PC) begin
        r_fetch_pc <= Alt_PC;
        r_epoch    <= ~r_epoch;
      end else if (w_tag_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end

      if (w_tag_push) r_tag_wr <= r_tag_wr + AW'(1);
      if (w_resp)     r_tag_rd <= r_tag_rd + AW'(1);
      r_outstanding <= r_outstanding + CW'(w_tag_push) - CW'(w_resp);

      // Redirect empties the buffer; older in-flight words die on epoch mismatch.
      if (Request_Alt_PC) begin
        r_buf_wr    <= '0;
        r_buf_rd    <= '0;
        r_buf_count <= '0;
      end else begin
        if (w_buf_push) r_buf_wr <= r_buf_wr + AW'(1);
        if (w_buf_pop)  r_buf_rd <= r_buf_rd + AW'(1);
        r_buf_count <= r_buf_count + CW'(w_buf_push) - CW'(w_buf_pop);
      end

      if (w_buf_pop) begin
        r_instr <= r_buf_ins[r_buf_rd];
        r_pc    <= r_buf_pc[r_buf_rd];
        r_pc4   <= r_buf_pc[r_buf_rd] + 32'd4;
        r_valid <= 1'b1;
      end else begin
        r_instr <= '0;
        r_pc    <= '0;
        r_pc4   <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_tag_push) begin
      r_tag_pc[r_tag_wr] <= r_fetch_pc;
      r_tag_ep[r_tag_wr] <= r_epoch;
    end
    if (w_buf_push) begin
      r_buf_pc[r_buf_wr]  <= r_tag_pc[r_tag_rd];
      r_buf_ins[r_buf_wr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model, queue-based reference of the
// fetch stage checked every cycle, plus directed scenarios with literal values.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Alt_PC = '0;
  logic        Request_Alt_PC = 1'b0;
  logic        WANT_FREEZE = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr1_out;
  logic [31:0] instr_pc_out;
  logic [31:0] instr_pc_plus4_out;
  logic        instr_valid;

  fetch_unit #(.RESET_PC(32'h0040_0000), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .Alt_PC(Alt_PC), .Request_Alt_PC(Request_Alt_PC),
    .WANT_FREEZE(WANT_FREEZE), .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr1_out(instr1_out), .instr_pc_out(instr_pc_out),
    .instr_pc_plus4_out(instr_pc_plus4_out), .instr_valid(instr_valid)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model: in-order, per-request latency ----------------
  typedef struct packed {logic [31:0] addr; int due;} mrsp_t;
  mrsp_t mq[$];
  int cyc = 0;
  int last_due = 0;
  int mem_lat = 1;
  bit lat_rand = 0;
  bit gnt_on = 0;
  bit gnt_rand = 0;
  int n_grants = 0;

  always @(posedge CLK) begin
    cyc++;
    #1;
    imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_on;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr ^ 32'h0000_FFFF;
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  always @(negedge CLK) begin
    int lat;
    int d;
    if (imem_req && imem_gnt) begin
      lat = lat_rand ? int'($urandom_range(1, 3)) : mem_lat;
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: imem_addr, due: d});
      n_grants++;
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  typedef struct packed {logic [31:0] pc; logic ep;} tag_t;
  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} ent_t;
  tag_t m_infl[$];
  ent_t m_obuf[$];
  logic [31:0] m_pc, m_o_ins, m_o_pc, m_o_pc4;
  logic        m_ep, m_o_v;
  bit          m_init = 0;
  bit          have_prev = 0;
  logic [31:0] prev_pc;
  int          n_valid = 0;

  always @(negedge CLK) begin
    logic exp_req;
    tag_t t;
    ent_t e;
    exp_req = RESET && !Request_Alt_PC && !WANT_FREEZE && !halt &&
              (m_infl.size() + m_obuf.size() < DEPTH);
    if (m_init) begin
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_o_v));
      chk("instr1_out", instr1_out, m_o_ins);
      chk("instr_pc_out", instr_pc_out, m_o_pc);
      chk("instr_pc_plus4_out", instr_pc_plus4_out, m_o_pc4);
      if (instr_valid === 1'b1) begin
        n_valid++;
        chk("data_matches_pc", instr1_out, instr_pc_out ^ 32'h0000_FFFF);
        if (have_prev) chk("pc_stream_plus4", instr_pc_out, prev_pc + 32'd4);
        have_prev = 1;
        prev_pc = instr_pc_out;
      end
    end
    if (!RESET) begin
      m_infl.delete();
      m_obuf.delete();
      m_pc = 32'h0040_0000;
      m_ep = 1'b0;
      m_o_v = 1'b0; m_o_ins = '0; m_o_pc = '0; m_o_pc4 = '0;
      m_init = 1;
      have_prev = 0;
    end else if (m_init) begin
      if (!Request_Alt_PC && !halt && m_obuf.size() > 0) begin
        e = m_obuf.pop_front();
        m_o_v = 1'b1; m_o_ins = e.ins; m_o_pc = e.pc; m_o_pc4 = e.pc + 32'd4;
      end else begin
        m_o_v = 1'b0; m_o_ins = '0; m_o_pc = '0; m_o_pc4 = '0;
      end
      if (imem_rvalid && m_infl.size() > 0) begin
        t = m_infl.pop_front();
        if (t.ep == m_ep && !Request_Alt_PC) m_obuf.push_back('{pc: t.pc, ins: imem_rdata});
      end
      if (exp_req && imem_gnt) begin
        m_infl.push_back('{pc: m_pc, ep: m_ep});
        m_pc = m_pc + 32'd4;
      end
      if (Request_Alt_PC) begin
        m_obuf.delete();
        m_pc = Alt_PC;
        m_ep = ~m_ep;
        have_prev = 0;
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input string name, output logic [31:0] pc, output logic [31:0] ins);
    int k;
    k = 0;
    pc = '0;
    ins = '0;
    while (k < 40) begin
      step();
      #2;
      if (instr_valid === 1'b1) break;
      k++;
    end
    if (k >= 40) chk({name, "_timeout"}, 32'd0, 32'd1);
    else begin
      pc = instr_pc_out;
      ins = instr1_out;
    end
  endtask

  initial begin
    logic [31:0] pc, ins, last_pc;
    int base_v, base_g, cnt, k;

    RESET = 1'b0;
    repeat (3) step();
    #2;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr1_out, 32'd0);
    chk("rst_pc", instr_pc_out, 32'd0);
    chk("rst_pc4", instr_pc_plus4_out, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);

    // streaming, 1-cycle memory
    step();
    RESET = 1'b1; gnt_on = 1; mem_lat = 1;
    #2;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0040_0000);
    wait_valid("p1", pc, ins);
    chk("p1_pc0", pc, 32'h0040_0000);
    chk("p1_ins0", ins, 32'h0040_FFFF);
    chk("p1_pc4_0", instr_pc_plus4_out, 32'h0040_0004);
    step(); #2;
    chk("p1_pc1", instr_pc_out, 32'h0040_0004);
    chk("p1_ins1", instr1_out, 32'h0040_FFFB);
    step(); #2;
    chk("p1_pc2", instr_pc_out, 32'h0040_0008);
    chk("p1_ins2", instr1_out, 32'h0040_FFF7);
    for (int i = 0; i < 6; i++) begin
      step(); #2;
      chk("p1_steady_valid", 32'(instr_valid), 32'd1);
    end

    // redirect with three requests in flight
    step();
    mem_lat = 3;
    k = 0;
    while (m_infl.size() < 3 && k < 20) begin step(); k++; end
    if (k >= 20) chk("redir_setup_timeout", 32'd0, 32'd1);
    Request_Alt_PC = 1'b1; Alt_PC = 32'h0040_1000;
    #2;
    chk("redir_no_req", 32'(imem_req), 32'd0);
    step();
    Request_Alt_PC = 1'b0; Alt_PC = 32'h1234_5678;
    #2;
    chk("redir_bubble", 32'(instr_valid), 32'd0);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h0040_1000);
    wait_valid("redir", pc, ins);
    chk("redir_first_pc", pc, 32'h0040_1000);
    chk("redir_first_ins", ins, 32'h0040_EFFF);

    // halt for ten cycles
    step();
    mem_lat = 1;
    repeat (6) step();
    halt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("halt_no_req", 32'(imem_req), 32'd0);
      if (i > 0) chk("halt_bubble", 32'(instr_valid), 32'd0);
      step();
    end
    halt = 1'b0;
    repeat (8) step();

    // freeze with exactly two requests in flight and nothing buffered
    WANT_FREEZE = 1'b1;
    repeat (10) step();
    mem_lat = 3;
    WANT_FREEZE = 1'b0;
    step();
    step();
    WANT_FREEZE = 1'b1;
    cnt = 0;
    last_pc = '0;
    for (int i = 0; i < 12; i++) begin
      step(); #2;
      chk("frz_no_req", 32'(imem_req), 32'd0);
      if (instr_valid === 1'b1) begin cnt++; last_pc = instr_pc_out; end
    end
    chk("frz_valid_count", 32'(cnt), 32'd2);
    step();
    WANT_FREEZE = 1'b0;
    #2;
    chk("frz_resume_req", 32'(imem_req), 32'd1);
    chk("frz_resume_addr", imem_addr, last_pc + 32'd4);
    repeat (6) step();

    // random grants, latency 1..3
    WANT_FREEZE = 1'b1;
    repeat (10) step();
    base_v = n_valid;
    base_g = n_grants;
    lat_rand = 1; gnt_rand = 1;
    WANT_FREEZE = 1'b0;
    repeat (80) step();
    WANT_FREEZE = 1'b1;
    repeat (14) step();
    gnt_rand = 0;
    chk("rand_valid_eq_grants", 32'(n_valid - base_v), 32'(n_grants - base_g));

    // reset mid-stream with responses pending
    lat_rand = 0; mem_lat = 3;
    WANT_FREEZE = 1'b0;
    repeat (5) step();
    RESET = 1'b0;
    #2;
    chk("mrst_no_req", 32'(imem_req), 32'd0);
    step();
    RESET = 1'b1; WANT_FREEZE = 1'b1;
    #2;
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    chk("mrst_instr", instr1_out, 32'd0);
    chk("mrst_pc", instr_pc_out, 32'd0);
    repeat (9) step();
    WANT_FREEZE = 1'b0;
    #2;
    chk("mrst_req", 32'(imem_req), 32'd1);
    chk("mrst_addr", imem_addr, 32'h0040_0000);
    wait_valid("mrst", pc, ins);
    chk("mrst_first_pc", pc, 32'h0040_0000);
    chk("mrst_first_ins", ins, 32'h0040_FFFF);
    WANT_FREEZE = 1'b1;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
